// File: rtl/loop_addr_gen_if.sv
// Address-stream interface for loop_addr_gen.
// Carries the launch/config inputs, the valid/ready address stream and the
// busy/done status. "master" is the address generator, "slave" is the
// controller/consumer that launches sequences and accepts addresses.
//   start        launch request (sampled only while the generator is idle)
//   base_addr    first address of the sequence
//   stride_inner address increment per inner step
//   stride_outer address increment per outer step
//   num_inner    inner trip count
//   num_outer    outer trip count
//   addr_valid   addr holds a valid address
//   addr_ready   consumer accepts addr this cycle
//   addr         current address
//   addr_last    addr is the final address of the sequence
//   busy         sequence in progress (RUN or DONE)
//   done         one-cycle completion pulse
interface loop_addr_gen_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ITER_WIDTH = 8
) ();

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] stride_inner;
  logic [ADDR_WIDTH-1:0] stride_outer;
  logic [ITER_WIDTH-1:0] num_inner;
  logic [ITER_WIDTH-1:0] num_outer;
  logic                  addr_valid;
  logic                  addr_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start,
    input  base_addr,
    input  stride_inner,
    input  stride_outer,
    input  num_inner,
    input  num_outer,
    input  addr_ready,
    output addr_valid,
    output addr,
    output addr_last,
    output busy,
    output done
  );

  modport slave (
    output start,
    output base_addr,
    output stride_inner,
    output stride_outer,
    output num_inner,
    output num_outer,
    output addr_ready,
    input  addr_valid,
    input  addr,
    input  addr_last,
    input  busy,
    input  done
  );

endinterface

// File: rtl/loop_addr_gen.sv
// Two-level nested-loop address generator.
// Turns inner/outer iteration indices into a stream of strided addresses
// addr = base + i*stride_inner + o*stride_outer (mod 2^ADDR_WIDTH), built
// with accumulators. The stream uses valid/ready and holds under stall.
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high
//   bus  loop_addr_gen_if.master: start/config in, address stream and
//        busy/done status out (all outputs registered)
module loop_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ITER_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  loop_addr_gen_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;

  // Latched configuration
  logic [ADDR_WIDTH-1:0] si_q, si_d;
  logic [ADDR_WIDTH-1:0] so_q, so_d;
  logic [ITER_WIDTH-1:0] ni_q, ni_d;
  logic [ITER_WIDTH-1:0] no_q, no_d;

  // Loop indices and address accumulators
  logic [ITER_WIDTH-1:0] i_q, i_d;
  logic [ITER_WIDTH-1:0] o_q, o_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

  // Registered outputs
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fire_c;
  logic                  inner_end_c;
  logic                  outer_end_c;

  assign fire_c      = valid_q && bus.addr_ready;
  assign inner_end_c = (i_q == (ni_q - ITER_WIDTH'(1)));
  assign outer_end_c = (o_q == (no_q - ITER_WIDTH'(1)));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      si_q       <= '0;
      so_q       <= '0;
      ni_q       <= '0;
      no_q       <= '0;
      i_q        <= '0;
      o_q        <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      si_q       <= si_d;
      so_q       <= so_d;
      ni_q       <= ni_d;
      no_q       <= no_d;
      i_q        <= i_d;
      o_q        <= o_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state, index/address stepping and next output values
  always_comb begin
    state_d    = state_q;
    si_d       = si_q;
    so_d       = so_q;
    ni_d       = ni_q;
    no_d       = no_q;
    i_d        = i_q;
    o_d        = o_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          si_d = bus.stride_inner;
          so_d = bus.stride_outer;
          ni_d = bus.num_inner;
          no_d = bus.num_outer;
          i_d  = '0;
          o_d  = '0;
          if ((bus.num_inner == '0) || (bus.num_outer == '0)) begin
            // Empty iteration space: report completion without addresses
            state_d = ST_DONE;
          end else begin
            state_d    = ST_RUN;
            addr_d     = bus.base_addr;
            row_base_d = bus.base_addr;
          end
        end
      end

      ST_RUN: begin
        if (fire_c) begin
          if (!inner_end_c) begin
            i_d    = i_q + ITER_WIDTH'(1);
            addr_d = addr_q + si_q;
          end else if (!outer_end_c) begin
            // Next row starts one outer stride past the current row start
            i_d        = '0;
            o_d        = o_q + ITER_WIDTH'(1);
            addr_d     = row_base_q + so_q;
            row_base_d = row_base_q + so_q;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so derive them from the state being entered
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    last_d  = valid_d &&
              (i_d == (ni_d - ITER_WIDTH'(1))) &&
              (o_d == (no_d - ITER_WIDTH'(1)));
  end

  assign bus.addr_valid = valid_q;
  assign bus.addr       = addr_q;
  assign bus.addr_last  = last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
